// File: rtl/unidad_control_multiciclo_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// opcodes, ALU codes, FSM states and datapath mux selects.
package cu_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ORI  = 4'b0001;
  localparam logic [3:0] ALU_R    = 4'b0010;
  localparam logic [3:0] ALU_ANDI = 4'b0011;
  localparam logic [3:0] ALU_LW   = 4'b0100;
  localparam logic [3:0] ALU_SW   = 4'b0101;
  localparam logic [3:0] ALU_SLTI = 4'b0110;
  localparam logic [3:0] ALU_BEQ  = 4'b0111;
  localparam logic [3:0] ALU_BNE  = 4'b1000;
  localparam logic [3:0] ALU_BGTZ = 4'b1001;

  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4;
  localparam logic [3:0] S_WB_ALU = 4'd5;
  localparam logic [3:0] S_ADDR   = 4'd6;
  localparam logic [3:0] S_MEM_RD = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_MEM_WR = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_OUT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  typedef enum logic [2:0] {
    CL_R, CL_I, CL_MEM, CL_BR, CL_J, CL_BAD
  } op_class_e;

  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e c;
    case (op)
      OP_R:    c = CL_R;
      OP_ADDI, OP_ORI,
      OP_ANDI, OP_SLTI: c = CL_I;
      OP_LW, OP_SW:     c = CL_MEM;
      OP_BEQ, OP_BNE,
      OP_BGTZ: c = CL_BR;
      OP_J:    c = CL_J;
      default: c = CL_BAD;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] alu_code(input logic [5:0] op);
    logic [3:0] a;
    case (op)
      OP_R:    a = ALU_R;
      OP_ORI:  a = ALU_ORI;
      OP_ANDI: a = ALU_ANDI;
      OP_LW:   a = ALU_LW;
      OP_SW:   a = ALU_SW;
      OP_SLTI: a = ALU_SLTI;
      OP_BEQ:  a = ALU_BEQ;
      OP_BNE:  a = ALU_BNE;
      OP_BGTZ: a = ALU_BGTZ;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/unidad_control_multiciclo_if.sv
// Control-unit <-> datapath bundle: opcode and memory
// handshake in, control strobes and status out.
interface unidad_control_multiciclo_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4,
  parameter int RET_W   = 16
);
  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic [1:0]         pc_source;
  logic               ir_write;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               instr_done;
  logic [RET_W-1:0]   retired;
  logic               illegal_op;
  logic               bus_err;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, pc_source,
    output ir_write, i_or_d, mem_read, mem_write,
    output mem_to_reg, reg_dst, reg_write,
    output alu_src_a, alu_src_b, alu_op,
    output instr_done, retired, illegal_op, bus_err
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, pc_source,
    input  ir_write, i_or_d, mem_read, mem_write,
    input  mem_to_reg, reg_dst, reg_write,
    input  alu_src_a, alu_src_b, alu_op,
    input  instr_done, retired, illegal_op, bus_err
  );
endinterface

// File: rtl/unidad_control_multiciclo_timer.sv
// Wait-state watchdog: counts cycles without mem_ready,
// expires on the TIMEOUT-th consecutive miss.
module cu_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (tick_i) cnt_d = cnt_q + 1'b1;
  end

  // cnt_q holds misses before this cycle, so a late ready still wins
  assign expire_o = tick_i && (cnt_q == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS control FSM with memory stall,
// illegal-opcode / bus-timeout traps and retire counter.
module unidad_control_multiciclo
  import cu_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 15,
  parameter int RET_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  unidad_control_multiciclo_if.master bus
);
  logic [3:0]      state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic            ill_q, ill_d;
  logic            berr_q, berr_d;
  logic            waiting, expire, done;
  op_class_e       cls_in, cls_q;

  assign cls_in = op_class(6'(bus.op));
  assign cls_q  = op_class(6'(op_q));

  assign waiting = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};

  cu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (!waiting || bus.mem_ready),
    .tick_i   (waiting && !bus.mem_ready),
    .expire_o (expire)
  );

  assign done = (state_q == S_WB_ALU) ||
                (state_q == S_WB_MEM) ||
                (state_q == S_BRANCH) ||
                (state_q == S_JUMP)   ||
                (state_q == S_MEM_WR && bus.mem_ready);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ill_d   = ill_q;
    berr_d  = berr_q;
    ret_d   = ret_q + RET_W'(done);
    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (expire) begin
          state_d = S_TRAP;
          berr_d  = 1'b1;
        end else if (bus.mem_ready) begin
          unique case (1'b1)
            state_q == S_FETCH:  state_d = S_DECODE;
            state_q == S_MEM_RD: state_d = S_WB_MEM;
            default:             state_d = S_FETCH;
          endcase
        end
      end
      S_DECODE: begin
        op_d = bus.op;
        unique case (cls_in)
          CL_R:   state_d = S_EXEC_R;
          CL_I:   state_d = S_EXEC_I;
          CL_MEM: state_d = S_ADDR;
          CL_BR:  state_d = S_BRANCH;
          CL_J:   state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            ill_d   = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR:
        state_d = (6'(op_q) == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_WB_ALU, S_WB_MEM,
      S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = PCS_ALU;
    bus.ir_write      = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_RT;
    bus.alu_op        = ALUOP_W'(ALU_ADD);
    unique case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_4;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = SRCB_IMM2;
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_W'(ALU_R);
      end
      S_EXEC_I, S_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALUOP_W'(alu_code(6'(op_q)));
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (cls_q == CL_R);
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALUOP_W'(alu_code(6'(op_q)));
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCS_OUT;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCS_JMP;
      end
      default: ;
    endcase
  end

  assign bus.instr_done = done;
  assign bus.retired    = ret_q;
  assign bus.illegal_op = ill_q;
  assign bus.bus_err    = berr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      op_q    <= '0;
      ret_q   <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ret_q   <= ret_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for the multicycle control unit; a
// second instance with RET_W=2 covers counter wrap.
module tb_unidad_control_multiciclo;
  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       rdy;
  int         n_cmp;
  int         n_bad;

  unidad_control_multiciclo_if b0 ();
  unidad_control_multiciclo_if #(.RET_W(2)) b1 ();

  assign b0.op        = op;
  assign b0.mem_ready = rdy;
  assign b1.op        = op;
  assign b1.mem_ready = rdy;

  unidad_control_multiciclo u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  unidad_control_multiciclo #(.RET_W(2)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  logic [18:0] ctl;
  assign ctl = {b0.pc_write, b0.pc_write_cond, b0.pc_source,
                b0.ir_write, b0.i_or_d, b0.mem_read,
                b0.mem_write, b0.mem_to_reg, b0.reg_dst,
                b0.reg_write, b0.alu_src_a, b0.alu_src_b,
                b0.alu_op, b0.instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(
    input logic pcw, pcc, input logic [1:0] pcs,
    input logic irw, iod, mr, mw, m2r, rd, rw, a,
    input logic [1:0] b, input logic [3:0] alu,
    input logic dn);
    return {pcw, pcc, pcs, irw, iod, mr, mw, m2r,
            rd, rw, a, b, alu, dn};
  endfunction

  logic [18:0] F_RDY, F_WAIT, DEC, WB_I;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_fetch();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op = 6'b001000;
    rdy = 1'b1;
    #2;
    n_cmp++;
    if (ctl !== 19'd0 || b0.retired !== 16'd0 ||
        b0.illegal_op !== 1'b0 || b0.bus_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got ctl=%h ret=%0d ill=%b be=%b want 0",
               ctl, b0.retired, b0.illegal_op, b0.bus_err);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctl !== 19'd0) begin
      n_bad++;
      $display("FAIL rst_state: got %h want 0", ctl);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (ctl !== F_RDY) begin
      n_bad++;
      $display("FAIL first_fetch: got %h want %h", ctl, F_RDY);
    end
  endtask

  task automatic test_addi();
    logic [18:0] e [5];
    e = '{F_RDY, DEC,
          mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,4'b0000,0),
          WB_I, F_RDY};
    go_fetch();
    op = 6'b001000;
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ctl !== e[i]) begin
        n_bad++;
        $display("FAIL addi c%0d: got %h want %h", i + 1, ctl, e[i]);
      end
      tick();
    end
    n_cmp++;
    if (b0.retired !== 16'd1) begin
      n_bad++;
      $display("FAIL addi_ret: got %0d want 1", b0.retired);
    end
  endtask

  task automatic test_rtype();
    logic [18:0] e [4];
    e = '{F_RDY, DEC,
          mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,4'b0010,0),
          mk(0,0,2'b00,0,0,0,0,0,1,1,0,2'b00,4'b0000,1)};
    go_fetch();
    op = 6'b000000;
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ctl !== e[i]) begin
        n_bad++;
        $display("FAIL rtype c%0d: got %h want %h", i + 1, ctl, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_lw();
    logic [18:0] e [9];
    logic r [9];
    logic [18:0] mrd;
    mrd = mk(0,0,2'b00,0,1,1,0,0,0,0,0,2'b00,4'b0000,0);
    e = '{F_RDY, DEC,
          mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,4'b0100,0),
          mrd, mrd, mrd, mrd,
          mk(0,0,2'b00,0,0,0,0,1,0,1,0,2'b00,4'b0000,1),
          F_RDY};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    go_fetch();
    op = 6'b100011;
    for (int i = 0; i < 9; i++) begin
      rdy = r[i];
      @(negedge clk);
      n_cmp++;
      if (ctl !== e[i]) begin
        n_bad++;
        $display("FAIL lw c%0d: got %h want %h", i + 1, ctl, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_sw();
    logic [18:0] e [6];
    logic r [6];
    e = '{F_RDY, DEC,
          mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,4'b0101,0),
          mk(0,0,2'b00,0,1,0,1,0,0,0,0,2'b00,4'b0000,0),
          mk(0,0,2'b00,0,1,0,1,0,0,0,0,2'b00,4'b0000,1),
          F_RDY};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    go_fetch();
    op = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      rdy = r[i];
      @(negedge clk);
      n_cmp++;
      if (ctl !== e[i]) begin
        n_bad++;
        $display("FAIL sw c%0d: got %h want %h", i + 1, ctl, e[i]);
      end
      tick();
    end
    n_cmp++;
    if (b0.retired !== 16'd1) begin
      n_bad++;
      $display("FAIL sw_ret: got %0d want 1", b0.retired);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [4];
    logic [18:0] e [4];
    logic [15:0] r16 [4];
    logic [1:0]  r2 [4];
    ops = '{6'b000100, 6'b000101, 6'b000111, 6'b000010};
    e = '{mk(0,1,2'b01,0,0,0,0,0,0,0,1,2'b00,4'b0111,1),
          mk(0,1,2'b01,0,0,0,0,0,0,0,1,2'b00,4'b1000,1),
          mk(0,1,2'b01,0,0,0,0,0,0,0,1,2'b00,4'b1001,1),
          mk(1,0,2'b10,0,0,0,0,0,0,0,0,2'b00,4'b0000,1)};
    r16 = '{16'd1, 16'd2, 16'd3, 16'd4};
    r2 = '{2'd1, 2'd2, 2'd3, 2'd0};
    go_fetch();
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = ops[i];
      tick();
      tick();
      @(negedge clk);
      n_cmp++;
      if (ctl !== e[i]) begin
        n_bad++;
        $display("FAIL branch%0d: got %h want %h", i, ctl, e[i]);
      end
      tick();
      n_cmp++;
      if (b0.retired !== r16[i] || b1.retired !== r2[i]) begin
        n_bad++;
        $display("FAIL ret%0d: got %0d/%0d want %0d/%0d",
                 i, b0.retired, b1.retired, r16[i], r2[i]);
      end
    end
  endtask

  task automatic test_trap();
    go_fetch();
    op = 6'b111111;
    rdy = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (b0.illegal_op !== 1'b0) begin
      n_bad++;
      $display("FAIL ill_early: got %b want 0", b0.illegal_op);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      rdy = i[0];
      @(negedge clk);
      n_cmp++;
      if (ctl !== 19'd0 || b0.illegal_op !== 1'b1 ||
          b0.bus_err !== 1'b0) begin
        n_bad++;
        $display("FAIL trap c%0d: got ctl=%h ill=%b be=%b want 0/1/0",
                 i, ctl, b0.illegal_op, b0.bus_err);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (b0.illegal_op !== 1'b0) begin
      n_bad++;
      $display("FAIL ill_clear: got %b want 0", b0.illegal_op);
    end
    tick();
    rst_n = 1'b1;
    rdy = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (ctl !== F_RDY) begin
      n_bad++;
      $display("FAIL trap_exit: got %h want %h", ctl, F_RDY);
    end
  endtask

  task automatic test_timeout();
    go_fetch();
    op = 6'b001000;
    rdy = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ctl !== F_WAIT || b0.bus_err !== 1'b0) begin
        n_bad++;
        $display("FAIL wait c%0d: got %h be=%b want %h be=0",
                 i, ctl, b0.bus_err, F_WAIT);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if (ctl !== 19'd0 || b0.bus_err !== 1'b1) begin
      n_bad++;
      $display("FAIL bus_err: got ctl=%h be=%b want 0/1", ctl, b0.bus_err);
    end
    go_fetch();
    for (int i = 1; i <= 14; i++) tick();
    rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctl !== F_RDY) begin
      n_bad++;
      $display("FAIL late_rdy: got %h want %h", ctl, F_RDY);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (ctl !== DEC || b0.bus_err !== 1'b0) begin
      n_bad++;
      $display("FAIL late_dec: got %h be=%b want %h be=0",
               ctl, b0.bus_err, DEC);
    end
  endtask

  task automatic test_reset_memwr();
    go_fetch();
    op = 6'b101011;
    rdy = 1'b1;
    tick();
    tick();
    tick();
    rdy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b0.mem_write !== 1'b1) begin
      n_bad++;
      $display("FAIL memwr_on: got %b want 1", b0.mem_write);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (b0.mem_write !== 1'b0 || ctl !== 19'd0) begin
      n_bad++;
      $display("FAIL memwr_rst: got mw=%b ctl=%h want 0", b0.mem_write, ctl);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    op     = '0;
    rdy    = 1'b0;
    rst_n  = 1'b0;
    F_RDY  = mk(1,0,2'b00,1,0,1,0,0,0,0,0,2'b01,4'b0000,0);
    F_WAIT = mk(0,0,2'b00,0,0,1,0,0,0,0,0,2'b01,4'b0000,0);
    DEC    = mk(0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,4'b0000,0);
    WB_I   = mk(0,0,2'b00,0,0,0,0,0,0,1,0,2'b00,4'b0000,1);
    test_reset();
    test_addi();
    test_rtype();
    test_lw();
    test_sw();
    test_back_to_back();
    test_trap();
    test_timeout();
    test_reset_memwr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
